whistle_seq: RTL and testbench

//  Whistle event sequencer, directly upstream of the whistle volume stage, driving its start input.

---
 rtl/whistle_pkg.sv | 18 +
 rtl/whistle_seq.sv | 105 ++++++++++
 tb/tb_whistle_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/whistle_pkg.sv
// Shared encodings for the whistle event sequencer.
package whistle_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPulse = 2'd1,
    StGap   = 2'd2
  } whistle_state_e;

  localparam logic [1:0] EV_SERVE   = 2'd0;
  localparam logic [1:0] EV_POINT   = 2'd1;
  localparam logic [1:0] EV_FAULT   = 2'd2;
  localparam logic [1:0] EV_SET_END = 2'd3;

  // One full ring plus wait of the volume stage; the shortest legal blast spacing.
  localparam int unsigned VOL_STAGE_CYCLE = 404;

endpackage

// File: rtl/whistle_seq.sv
// Whistle event sequencer: expands referee events into 1-4 start pulses spaced GAP_CYCLES apart,
// with a one-deep pending slot, busy flag and sticky overflow flag.
module whistle_seq
  import whistle_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 512,
  parameter int unsigned CTR_W      = 10
) (
  input  logic       clk_slow,
  input  logic       rst,
  input  logic       ev_valid,
  input  logic [1:0] ev_code,
  output logic       ev_ready,
  output logic       start,
  output logic       busy,
  output logic       ovf
);

  if (GAP_CYCLES < VOL_STAGE_CYCLE) begin : gen_bad_gap
    $error("GAP_CYCLES shorter than one volume stage cycle");
  end

  localparam logic [CTR_W-1:0] CtrLast = CTR_W'(GAP_CYCLES - 2);

  whistle_state_e   state_q, state_d;
  logic             pend_vld_q, pend_vld_d;
  logic [1:0]       pend_code_q, pend_code_d;
  logic [1:0]       blasts_left_q, blasts_left_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             accept, consume;

  assign ev_ready = ~pend_vld_q;
  assign accept   = ev_valid & ~pend_vld_q;

  always_comb begin
    state_d       = state_q;
    blasts_left_d = blasts_left_q;
    ctr_d         = ctr_q;
    start_d       = 1'b0;
    consume       = 1'b0;
    case (state_q)
      StIdle: begin
        if (pend_vld_q) begin
          state_d       = StPulse;
          start_d       = 1'b1;
          blasts_left_d = pend_code_q;
          consume       = 1'b1;
        end
      end
      StPulse: begin
        ctr_d   = '0;
        state_d = StGap;
      end
      StGap: begin
        ctr_d = ctr_q + CTR_W'(1);
        // Terminal count lands the next start exactly GAP_CYCLES after the previous one.
        if (ctr_q == CtrLast) begin
          if (blasts_left_q != 2'd0) begin
            state_d       = StPulse;
            start_d       = 1'b1;
            blasts_left_d = blasts_left_q - 2'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    pend_vld_d  = accept ? 1'b1 : (consume ? 1'b0 : pend_vld_q);
    pend_code_d = accept ? ev_code : pend_code_q;
    ovf_d       = ovf_q | (ev_valid & pend_vld_q);
    busy_d      = (state_d != StIdle) | pend_vld_d;
  end

  always_ff @(posedge clk_slow) begin
    if (rst) begin
      state_q       <= StIdle;
      pend_vld_q    <= 1'b0;
      pend_code_q   <= 2'd0;
      blasts_left_q <= 2'd0;
      ctr_q         <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_vld_q    <= pend_vld_d;
      pend_code_q   <= pend_code_d;
      blasts_left_q <= blasts_left_d;
      ctr_q         <= ctr_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      ovf_q         <= ovf_d;
    end
  end

  assign start = start_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_whistle_seq.sv
// Self-checking bench for whistle_seq: event-level timeline model plus directed timing checks.
module tb_whistle_seq;

  localparam longint GAP = 512;

  logic       clk_slow = 1'b0;
  logic       rst      = 1'b0;
  logic       ev_valid = 1'b0;
  logic [1:0] ev_code  = 2'd0;
  logic       ev_ready, start, busy, ovf;

  int checks   = 0;
  int failures = 0;

  whistle_seq #(.GAP_CYCLES(512), .CTR_W(10)) dut (
    .clk_slow (clk_slow),
    .rst      (rst),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_ready (ev_ready),
    .start    (start),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk_slow = ~clk_slow;

  // Timeline model: a consumed event schedules all its start times at once and marks the
  // edge after which the sequencer is idle again.
  longint cyc     = 0;
  longint idle_at = 0;
  longint sched[$];
  bit     chk_en  = 1'b0;
  bit     m_pend  = 1'b0;
  logic [1:0] m_code = 2'd0;
  bit     m_start = 1'b0;
  bit     m_busy  = 1'b0;
  bit     m_ovf   = 1'b0;

  always @(posedge clk_slow) begin
    bit old_pend;
    cyc++;
    if (rst) begin
      m_pend  = 1'b0;
      m_ovf   = 1'b0;
      m_start = 1'b0;
      idle_at = cyc;
      sched.delete();
      chk_en  = 1'b1;
    end else begin
      old_pend = m_pend;
      if (cyc > idle_at && old_pend) begin
        for (int k = 0; k <= int'(m_code); k++) sched.push_back(cyc + GAP * k);
        idle_at = cyc + GAP * (longint'(m_code) + 1);
        m_pend  = 1'b0;
      end
      if (ev_valid) begin
        if (!old_pend) begin
          m_pend = 1'b1;
          m_code = ev_code;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_start = 1'b0;
      if (sched.size() > 0 && sched[0] == cyc) begin
        m_start = 1'b1;
        void'(sched.pop_front());
      end
    end
    m_busy = (cyc < idle_at) || m_pend;
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at cyc=%0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  // Per-cycle compare against the model, plus logs of observed start and busy-fall edges.
  longint start_log[$];
  longint busy_fall[$];
  logic   busy_prev = 1'b0;

  always @(negedge clk_slow) begin
    if (chk_en) begin
      check("start", longint'(start), longint'(m_start));
      check("busy", longint'(busy), longint'(m_busy));
      check("ovf", longint'(ovf), longint'(m_ovf));
      check("ev_ready", longint'(ev_ready), longint'(!m_pend));
      if (start === 1'b1) start_log.push_back(cyc);
      if (busy_prev === 1'b1 && busy === 1'b0) busy_fall.push_back(cyc);
      busy_prev = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_slow);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic post(input logic [1:0] c, output longint acc);
    ev_valid = 1'b1;
    ev_code  = c;
    tick(1);
    acc      = cyc;
    ev_valid = 1'b0;
    ev_code  = 2'($urandom);
  endtask

  longint a, b, c;

  initial begin
    // 1: reset state, single blast latency and busy duration
    do_reset();
    check("rst_start", longint'(start), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst_ready", longint'(ev_ready), 1);
    start_log.delete();
    busy_fall.delete();
    post(2'd0, a);
    tick(600);
    check("t1_count", longint'(start_log.size()), 1);
    if (start_log.size() >= 1) begin
      check("t1_latency", start_log[0] - a, 1);
      check("t1_busy_fall_count", longint'(busy_fall.size()), 1);
      if (busy_fall.size() >= 1) check("t1_busy_len", busy_fall[0] - start_log[0], 512);
    end

    // 2: four-blast event
    start_log.delete();
    post(2'd3, a);
    tick(2200);
    check("t2_count", longint'(start_log.size()), 4);
    if (start_log.size() == 4) begin
      check("t2_first", start_log[0] - a, 1);
      check("t2_gap1", start_log[1] - start_log[0], 512);
      check("t2_gap2", start_log[2] - start_log[1], 512);
      check("t2_gap3", start_log[3] - start_log[2], 512);
    end
    check("t2_idle", longint'(busy), 0);

    // 3: second event held pending behind a two-blast event
    start_log.delete();
    post(2'd1, a);
    tick(9);
    post(2'd0, b);
    check("t3_ready_low", longint'(ev_ready), 0);
    check("t3_busy", longint'(busy), 1);
    tick(1700);
    check("t3_count", longint'(start_log.size()), 3);
    if (start_log.size() == 3) begin
      check("t3_gap1", start_log[1] - start_log[0], 512);
      check("t3_next_event", start_log[2] - start_log[1], 513);
    end

    // 4: third request while pattern runs and slot is full
    start_log.delete();
    post(2'd1, a);
    tick(5);
    post(2'd0, b);
    tick(5);
    check("t4_ovf_before", longint'(ovf), 0);
    post(2'd2, c);
    check("t4_ovf_set", longint'(ovf), 1);
    tick(2000);
    check("t4_ovf_sticky", longint'(ovf), 1);
    check("t4_count", longint'(start_log.size()), 3);
    if (start_log.size() == 3) begin
      check("t4_first", start_log[0] - a, 1);
      check("t4_gap1", start_log[1] - start_log[0], 512);
      check("t4_second_ev", start_log[2] - start_log[1], 513);
    end

    // 5: reset mid-gap aborts the pattern
    do_reset();
    start_log.delete();
    post(2'd2, a);
    tick(100);
    do_reset();
    check("t5_ovf", longint'(ovf), 0);
    check("t5_ready", longint'(ev_ready), 1);
    check("t5_busy", longint'(busy), 0);
    tick(1200);
    check("t5_count", longint'(start_log.size()), 1);

    // 6: request held high continuously
    start_log.delete();
    ev_valid = 1'b1;
    ev_code  = 2'd0;
    tick(1);
    a = cyc;
    check("t6_ovf_first", longint'(ovf), 0);
    tick(1);
    check("t6_ovf_reject", longint'(ovf), 1);
    tick(1100);
    ev_valid = 1'b0;
    tick(600);
    check("t6_count", longint'(start_log.size()), 4);
    if (start_log.size() >= 3) begin
      check("t6_first", start_log[0] - a, 1);
      check("t6_gap1", start_log[1] - start_log[0], 513);
      check("t6_gap2", start_log[2] - start_log[1], 513);
    end

    // Random traffic with occasional resets, checked cycle by cycle against the model.
    do_reset();
    for (int i = 0; i < 15000; i++) begin
      ev_code  = 2'($urandom);
      ev_valid = ($urandom_range(0, 299) == 0) || (ev_valid && $urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 3999) == 0);
      tick(1);
    end
    ev_valid = 1'b0;
    rst      = 1'b0;
    tick(2200);
    check("final_idle", longint'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
